// File: rtl/dma_pkg.sv
// Shared types and constants for the bus DMA master.
// Optional fill mode is enabled with `define DMA_FILL_EN.
package dma_pkg;

  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 8;
  localparam int RD_LATENCY_DEF = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    READ,
    WPEND,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/bus_dma_master_if.sv
// Command and CPU-side bus bundle for the DMA master.
// CMD_FILL/CMD_FILL_DATA exist only with `define DMA_FILL_EN.
interface bus_dma_master_if;
  import dma_pkg::*;

  logic  CMD_VALID;
  logic  CMD_READY;
  addr_t CMD_SRC;
  addr_t CMD_DST;
  addr_t CMD_LEN;
`ifdef DMA_FILL_EN
  logic  CMD_FILL;
  data_t CMD_FILL_DATA;
`endif
  logic  BUS_REQ;
  logic  BUS_GNT;
  addr_t A;
  data_t DO;
  data_t DI;
  logic  R_W_n;
  logic  BUSY;
  logic  DONE;
  addr_t REMAIN;

  modport master (
`ifdef DMA_FILL_EN
    input  CMD_FILL, CMD_FILL_DATA,
`endif
    input  CMD_VALID, CMD_SRC, CMD_DST,
    input  CMD_LEN, BUS_GNT, DI,
    output CMD_READY, BUS_REQ, A, DO,
    output R_W_n, BUSY, DONE, REMAIN
  );

  modport slave (
`ifdef DMA_FILL_EN
    output CMD_FILL, CMD_FILL_DATA,
`endif
    output CMD_VALID, CMD_SRC, CMD_DST,
    output CMD_LEN, BUS_GNT, DI,
    input  CMD_READY, BUS_REQ, A, DO,
    input  R_W_n, BUSY, DONE, REMAIN
  );

endinterface

// File: rtl/bus_dma_master.sv
// Bus initiator copying a byte block src->dst via read/write cycles.
// `define DMA_FILL_EN adds a fill mode that skips the read phase.
module bus_dma_master
  import dma_pkg::*;
#(
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input logic              CLK,
  input logic              RESET,
  bus_dma_master_if.master bus
);

  localparam int LAT_W =
    (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST =
    LAT_W'(RD_LATENCY - 1);

  state_t           state_q;
  addr_t            src_q;
  addr_t            dst_q;
  addr_t            remain_q;
  addr_t            a_q;
  data_t            data_q;
  data_t            do_q;
  logic [LAT_W-1:0] lat_q;
  logic             ready_q;
  logic             req_q;
  logic             rw_q;
  logic             busy_q;
  logic             done_q;
`ifdef DMA_FILL_EN
  logic             fill_q;
`endif

  assign bus.CMD_READY = ready_q;
  assign bus.BUS_REQ   = req_q;
  assign bus.A         = a_q;
  assign bus.DO        = do_q;
  assign bus.R_W_n     = rw_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.REMAIN    = remain_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
      a_q      <= '0;
      data_q   <= '0;
      do_q     <= '0;
      lat_q    <= '0;
      ready_q  <= 1'b1;
      req_q    <= 1'b0;
      rw_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DMA_FILL_EN
      fill_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.CMD_VALID) begin
            src_q    <= bus.CMD_SRC;
            dst_q    <= bus.CMD_DST;
            remain_q <= bus.CMD_LEN;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef DMA_FILL_EN
            fill_q   <= bus.CMD_FILL;
            data_q   <= bus.CMD_FILL_DATA;
`endif
            if (bus.CMD_LEN == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= GRANT;
              req_q   <= 1'b1;
            end
          end
        end
        GRANT: begin
          if (bus.BUS_GNT) begin
`ifdef DMA_FILL_EN
            if (fill_q) begin
              state_q <= WRITE;
              a_q     <= dst_q;
              do_q    <= data_q;
              rw_q    <= 1'b0;
            end else
`endif
            begin
              state_q <= READ;
              a_q     <= src_q;
              rw_q    <= 1'b1;
              lat_q   <= LAT_LAST;
            end
          end
        end
        READ: begin
          // Read runs to completion even if grant drops.
          if (lat_q == '0) begin
            data_q <= bus.DI;
            if (bus.BUS_GNT) begin
              state_q <= WRITE;
              a_q     <= dst_q;
              do_q    <= bus.DI;
              rw_q    <= 1'b0;
            end else begin
              state_q <= WPEND;
            end
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        WPEND: begin
          if (bus.BUS_GNT) begin
            state_q <= WRITE;
            a_q     <= dst_q;
            do_q    <= data_q;
            rw_q    <= 1'b0;
          end
        end
        WRITE: begin
          rw_q     <= 1'b1;
          src_q    <= src_q + 16'd1;
          dst_q    <= dst_q + 16'd1;
          remain_q <= remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            req_q   <= 1'b0;
          end else begin
            state_q <= GRANT;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Scoreboard bench for bus_dma_master with a RAM/ROM responder model.
// Fill-mode cases are built only with `define DMA_FILL_EN.
module tb_bus_dma_master;
  import dma_pkg::*;

  localparam int RDL = RD_LATENCY_DEF;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic [15:0] rem;
  } wr_t;

  typedef struct {
    int at;
    bit chk;
  } dn_t;

  logic CLK = 1'b0;
  logic RESET;

  bus_dma_master_if bus();

  bus_dma_master #(.RD_LATENCY(RDL)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  wr_t  exp_wr[$];
  dn_t  exp_dn[$];
  logic [7:0] mem  [65536];
  logic [7:0] refm [65536];
  logic [7:0] di_q;
  int n_chk   = 0;
  int n_fail  = 0;
  int ncnt    = 0;
  int wr_seen = 0;
  int gmode   = 0;
  int gcnt    = 0;
  bit prev_w  = 0;

  // Responder: one registered stage gives 2-clock read latency.
  assign bus.DI = di_q;
  always @(posedge CLK) begin
    if (bus.R_W_n === 1'b0) mem[bus.A] <= bus.DO;
    di_q <= mem[bus.A];
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out, got none expected event", nm);
  endtask

  task automatic check_reset(input string nm);
    check(nm, {bus.CMD_READY, bus.BUS_REQ, bus.A,
               bus.DO, bus.R_W_n, bus.BUSY,
               bus.DONE, bus.REMAIN},
          {1'b1, 1'b0, 16'h0, 8'h0, 1'b1,
           1'b0, 1'b0, 16'h0});
  endtask

  // Monitor: pops the scoreboard on every write cycle and DONE.
  initial forever begin
    @(negedge CLK);
    ncnt++;
    if (bus.R_W_n === 1'b0) begin
      wr_seen++;
      check("wr_gnt", 64'(bus.BUS_GNT), 64'd1);
      check("wr_back2back", 64'(prev_w), 64'd0);
      check("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
      if (exp_wr.size() > 0) begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", 64'(bus.A), 64'(e.a));
        check("wr_data", 64'(bus.DO), 64'(e.d));
        check("wr_remain", 64'(bus.REMAIN), 64'(e.rem));
      end
    end
    prev_w = (bus.R_W_n === 1'b0);
    if (bus.DONE === 1'b1) begin
      check("done_expected", 64'(exp_dn.size() > 0), 64'd1);
      if (exp_dn.size() > 0) begin
        dn_t d;
        d = exp_dn.pop_front();
        if (d.chk) check("done_cycle", 64'(ncnt), 64'(d.at));
      end
      check("done_drained", 64'(exp_wr.size()), 64'd0);
      check("done_req", 64'(bus.BUS_REQ), 64'd0);
    end
  end

  // Arbiter model: tied, random, or 3-high/5-low periodic grant.
  initial begin
    bus.BUS_GNT = 1'b1;
    forever begin
      @(negedge CLK);
      #2;
      gcnt++;
      case (gmode)
        0:       bus.BUS_GNT = 1'b1;
        1:       bus.BUS_GNT = 1'($urandom_range(0, 1));
        default: bus.BUS_GNT = ((gcnt % 8) < 3);
      endcase
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      #1;
      if (bus.CMD_READY === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("cmd_ready");
  endtask

  task automatic issue(input logic [15:0] src,
                       input logic [15:0] dst,
                       input logic [15:0] len,
                       input bit          fill,
                       input logic [7:0]  fd,
                       input int          gm,
                       input int          abort_after);
    bit ok;
    int n;
    int lat;
`ifndef DMA_FILL_EN
    fill = 0;
`endif
    wait_ready(ok);
    if (!ok) return;
    gmode = gm;
    n = (abort_after >= 0 && abort_after < int'(len))
        ? abort_after : int'(len);
    // Reference: forward byte-by-byte copy, addresses wrap at 64K.
    for (int i = 0; i < n; i++) begin
      logic [15:0] sa, da;
      logic [7:0]  v;
      sa = src + 16'(i);
      da = dst + 16'(i);
      v  = fill ? fd : refm[sa];
      refm[da] = v;
      exp_wr.push_back('{da, v, len - 16'(i)});
    end
    lat = int'(len) * (fill ? 2 : RDL + 2);
    if (abort_after < 0)
      exp_dn.push_back('{ncnt + 1 + lat, gm == 0});
    bus.CMD_SRC = src;
    bus.CMD_DST = dst;
    bus.CMD_LEN = len;
`ifdef DMA_FILL_EN
    bus.CMD_FILL      = fill;
    bus.CMD_FILL_DATA = fd;
`endif
    bus.CMD_VALID = 1'b1;
    @(posedge CLK);
    #1;
    bus.CMD_VALID = 1'b0;
    if (len != 0) begin
      repeat (2) begin
        @(negedge CLK);
        #1;
        bus.CMD_SRC   = 16'($urandom);
        bus.CMD_DST   = 16'($urandom);
        bus.CMD_LEN   = 16'($urandom_range(1, 9));
        bus.CMD_VALID = 1'b1;
        check("busy_ready", 64'(bus.CMD_READY), 64'd0);
        @(posedge CLK);
        #1;
        bus.CMD_VALID = 1'b0;
      end
    end
  endtask

  task automatic finish_cmd(input logic [15:0] dst,
                            input logic [15:0] len);
    bit ok;
    wait_ready(ok);
    repeat (2) @(negedge CLK);
    for (int i = 0; i < int'(len); i++) begin
      logic [15:0] da;
      da = dst + 16'(i);
      check("mem", 64'(mem[da]), 64'(refm[da]));
    end
  endtask

  initial begin
    bit          ok;
    int          base;
    logic [7:0]  keep;
    logic [15:0] s, d, l;
    bit          f;

    for (int i = 0; i < 65536; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem[i]  = v;
      refm[i] = v;
    end
    bus.CMD_VALID = 1'b0;
    bus.CMD_SRC   = '0;
    bus.CMD_DST   = '0;
    bus.CMD_LEN   = '0;
`ifdef DMA_FILL_EN
    bus.CMD_FILL      = 1'b0;
    bus.CMD_FILL_DATA = '0;
`endif
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset("reset_values");
    #1;
    RESET = 1'b0;

    issue(16'hE000, 16'h0100, 16'd4, 0, 8'h00, 0, -1);
    finish_cmd(16'h0100, 16'd4);

    issue(16'h1234, 16'h4321, 16'd0, 0, 8'h00, 0, -1);
    finish_cmd(16'h4321, 16'd0);

    issue(16'hFFFE, 16'hFFFF, 16'd3, 0, 8'h00, 0, -1);
    finish_cmd(16'hFFFF, 16'd3);

    issue(16'h2000, 16'h2800, 16'd4, 0, 8'h00, 2, -1);
    finish_cmd(16'h2800, 16'd4);

    keep = refm[16'h3102];
    base = wr_seen;
    issue(16'h3000, 16'h3100, 16'd5, 0, 8'h00, 0, 2);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (wr_seen >= base + 2) begin
        ok = 1;
        break;
      end
      @(negedge CLK);
      #1;
    end
    if (!ok) timeout("abort_wait");
    RESET = 1'b1;
    @(negedge CLK);
    check_reset("abort_reset_values");
    #1;
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check("abort_3rd_byte", 64'(mem[16'h3102]), 64'(keep));
    finish_cmd(16'h3100, 16'd2);

`ifdef DMA_FILL_EN
    issue(16'h0000, 16'h0200, 16'd3, 1, 8'h5A, 0, -1);
    finish_cmd(16'h0200, 16'd3);
`endif

    for (int k = 0; k < 12; k++) begin
      s = 16'($urandom);
      if (k % 4 == 1) s = 16'hFFFC;
      d = (k % 3 == 2) ? s + 16'd1 : 16'($urandom);
      l = 16'($urandom_range(0, 6));
      f = 1'($urandom_range(0, 1));
      issue(s, d, l, f, 8'($urandom),
            int'($urandom_range(0, 2)), -1);
      finish_cmd(d, l);
    end

    repeat (5) @(negedge CLK);
    check("final_wr_queue", 64'(exp_wr.size()), 64'd0);
    check("final_done_queue", 64'(exp_dn.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
